fork_join_timer: RTL
====================

Name: fork_join_timer

Overview:
- Synthesizable, parametrised multi-channel event scheduler that generalises fork/join delay launching to hardware.
- One start pulse launches N_CH independent down-counters in parallel. Each channel emits a one-cycle fire pulse after its own programmed delay.
- A join pulse is produced per the selected mode: JOIN (all), JOIN_ANY (first) or JOIN_NONE (immediate).
- Sits in the test/stimulus infrastructure as a programmable delayed-event sequencer.

Parameters:
- N_CH, 4, number of channels (1..32).
- CNT_W, 8, width of each channel delay value.
- TIMEOUT, 256, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  launch request, sampled each cycle.
- abort_i  input  1  synchronous cancel of an active launch.
- mode_i  input  2  0=JOIN, 1=JOIN_ANY, 2=JOIN_NONE, 3=treated as JOIN; latched at start.
- delay_i  input  N_CH*CNT_W  per-channel delays, channel i in bits [i*CNT_W +: CNT_W]; latched at start.
- fire_o  output  N_CH  one-cycle pulse per channel when its delay expires.
- join_o  output  1  one-cycle join pulse.
- busy_o  output  1  high while state is not IDLE.
- fired_mask_o  output  N_CH  sticky record of channels fired in the current launch; cleared at next accepted start.
- start_drop_o  output  1  one-cycle pulse when start_i is ignored.
- timeout_o  output  1  watchdog pulse; tied 0 when the optional feature is off.

Behaviour:
- Reset: all outputs 0, all counters 0, state IDLE, latched mode = JOIN.
- Timing origin: start_i is accepted in cycle t only if state is IDLE.
- Channel delay d:
  - d = 0: channel disabled. It never fires and is excluded from join evaluation.
  - d >= 1: fire_o[i] is high exactly in cycle t+d.
- Multiple channels may fire in the same cycle.
- States:
  - IDLE -> WAIT when start is accepted.
  - WAIT -> DRAIN when the join condition is met and enabled channels are still pending.
  - WAIT -> IDLE when the join condition is met and no channels are pending.
  - DRAIN -> IDLE in the cycle after the last enabled channel fires.
- Join condition:
  - JOIN: join_o pulses in the same cycle as the last enabled fire.
  - JOIN_ANY: join_o pulses in the same cycle as the first fire. Simultaneous first fires give exactly one pulse.
  - JOIN_NONE: join_o pulses at t+1 regardless of delays.
  - All channels disabled: join_o pulses at t+1 in every mode, and busy_o falls at t+2.
- busy_o:
  - Rises at t+1.
  - Stays high through the cycle of the last fire (or the join pulse, if later).
  - Falls in the following cycle.
- start_i while state is not IDLE: ignored. start_drop_o pulses in the next cycle. Latched delays and mode are unaffected.
- abort_i while busy:
  - All counters clear and no further fire or join pulses occur.
  - State returns to IDLE; busy_o is 0 in the next cycle.
  - fired_mask_o is retained.
- abort_i and start_i in the same cycle: abort wins; a start from IDLE is not accepted and start_drop_o is not asserted.
- abort_i in IDLE: no effect.
- Counter wrap: not possible. Counters decrement only from a non-zero value and saturate at 0.
- rst mid-launch: same as abort, plus all outputs and fired_mask_o cleared.

Optional Feature:
- Macro FORK_JOIN_TIMER_WATCHDOG_EN.
- Defined:
  - A cycle counter runs while busy_o is high.
  - Reaching TIMEOUT cycles pulses timeout_o for one cycle and performs an internal abort with the same semantics as abort_i. join_o is not asserted.
  - The counter clears on IDLE.
- Undefined: the watchdog counter is absent and timeout_o is tied to 0.

Decomposition:
- Package fork_join_timer_pkg:
  - join_mode_e enum {JOIN, JOIN_ANY, JOIN_NONE}.
  - state_e enum {IDLE, WAIT, DRAIN}.
  - Mode decode function mapping 2'd3 to JOIN.
- Sub-module fork_join_timer_chan:
  - One channel: load, decrement, enable flag, fire pulse, pending flag.
  - Instantiated N_CH times in a generate loop.
- Top level holds the FSM, join logic, mask, drop detection and the watchdog.

Test Plan:
- Delays {1,2,4,5}, JOIN_NONE, start at cycle 0 -> join_o@1; fire[0]@1, fire[1]@2, fire[2]@4, fire[3]@5; busy_o low @6.
- Delays {1,2,4,5}, JOIN -> join_o@5 coincident with fire[3]; no other join pulse; fired_mask_o=4'hF.
- Delays {3,3,0,7}, JOIN_ANY -> fire[0] and fire[1]@3; single join_o@3; fire[3]@7; channel 2 never fires; fired_mask_o=4'hB.
- Delays {1,2,4,5}, JOIN, abort_i@3 -> only fire[0]@1 and fire[1]@2; no join_o; busy_o low @4; fired_mask_o=4'h3.
- Start@0 with delays {10,0,0,0}, second start@4 -> start_drop_o@5; fire[0] still @10; then start with all delays 0 -> join_o next cycle, busy_o low the cycle after.
- With the macro defined, TIMEOUT=6, delays {200,0,0,0}, JOIN -> timeout_o@7; no fire or join pulses; busy_o low @8. Without the macro, same stimulus -> fire[0]@200.

Source files
------------

// File: rtl/fork_join_timer_pkg.sv
// Shared types for fork_join_timer: join modes, FSM states and the mode decoder.
package fork_join_timer_pkg;

    typedef enum logic [1:0] {
        JOIN      = 2'd0,
        JOIN_ANY  = 2'd1,
        JOIN_NONE = 2'd2
    } join_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Encoding 3 is reserved and behaves as a full join.
    function automatic join_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return JOIN_ANY;
            2'd2:    return JOIN_NONE;
            default: return JOIN;
        endcase
    endfunction

endpackage

// File: rtl/fork_join_timer_chan.sv
// One delay channel: loads its delay on launch, counts down to a single fire cycle.
module fork_join_timer_chan #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr,
    input  logic [CNT_W-1:0] dly,
    output logic             fire,
    output logic             pend,
    output logic             more
);
    logic [CNT_W-1:0] cnt;
    logic             en;

    // Clear beats load so an abort in the launch cycle leaves the channel idle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            en  <= 1'b0;
        end else if (load) begin
            cnt <= dly;
            en  <= |dly;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Count of 1 in cycle t+k means k == delay, so that is the fire cycle.
    assign fire = en && (cnt == CNT_W'(1));
    assign pend = (cnt != '0);
    assign more = (cnt > CNT_W'(1));

endmodule

// File: rtl/fork_join_timer.sv
// Multi-channel fork/join delay scheduler with JOIN / JOIN_ANY / JOIN_NONE join pulse.
// Optional watchdog abort enabled by defining FORK_JOIN_TIMER_WATCHDOG_EN.
module fork_join_timer
    import fork_join_timer_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [1:0]            mode_i,
    input  logic [N_CH*CNT_W-1:0] delay_i,
    output logic [N_CH-1:0]       fire_o,
    output logic                  join_o,
    output logic                  busy_o,
    output logic [N_CH-1:0]       fired_mask_o,
    output logic                  start_drop_o,
    output logic                  timeout_o
);
    state_e          state, state_nxt;
    join_mode_e      mode_q;
    logic [N_CH-1:0] fire_raw, pend, more, mask_q;
    logic            busy, kill, accept, join_cond, timeout, drop_q;

    assign busy   = (state != IDLE);
    assign kill   = busy && (abort_i || timeout);
    assign accept = (state == IDLE) && start_i && !abort_i;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        fork_join_timer_chan #(.CNT_W(CNT_W)) u_chan (
            .clk  (clk),
            .rst  (rst),
            .load (accept),
            .clr  (kill),
            .dly  (delay_i[g*CNT_W +: CNT_W]),
            .fire (fire_raw[g]),
            .pend (pend[g]),
            .more (more[g])
        );
    end

    // A launch with no enabled channels satisfies every mode immediately.
    always_comb begin
        join_cond = 1'b0;
        case (mode_q)
            JOIN_ANY:  join_cond = (|fire_raw) || !(|pend);
            JOIN_NONE: join_cond = 1'b1;
            default:   join_cond = !(|more);
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = WAIT;
                WAIT:    if (join_cond) state_nxt = (|more) ? DRAIN : IDLE;
                DRAIN:   if (!(|more)) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign fire_o = kill ? '0 : fire_raw;
    assign join_o = (state == WAIT) && join_cond && !kill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= JOIN;
            mask_q <= '0;
            drop_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            drop_q <= busy && start_i && !abort_i;
            if (accept) begin
                mode_q <= decode_mode(mode_i);
                mask_q <= '0;
            end else begin
                mask_q <= mask_q | fire_o;
            end
        end
    end

`ifdef FORK_JOIN_TIMER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd;

    // wd holds the number of busy cycles already completed.
    always_ff @(posedge clk) begin
        if (rst || !busy)
            wd <= '0;
        else if (wd != WD_W'(TIMEOUT))
            wd <= wd + 1'b1;
    end

    assign timeout = busy && (wd == WD_W'(TIMEOUT));
`else
    assign timeout = 1'b0;
`endif

    assign busy_o       = busy;
    assign fired_mask_o = mask_q;
    assign start_drop_o = drop_q;
    assign timeout_o    = timeout;

endmodule
